// File: rtl/alarm_pkg.sv
// ============================================================================
// Package : alarm_pkg
// Purpose : Shared constants for the alarm-clock display driver: active-low
//           7-segment patterns (gfedcba order), scan state encoding and the
//           default timing parameters.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package alarm_pkg;

    localparam int DWELL_DEFAULT      = 4;
    localparam int BLINK_HALF_DEFAULT = 250;

    // Active-low segment patterns, bit order g f e d c b a.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // Digit 0-9 to segment pattern; anything else renders as a dash.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd60.sv
// ============================================================================
// Module  : bin2bcd60
// Purpose : Combinational binary-to-BCD split for values 0-59 (tens/units).
// Ports   : bin_i   [5:0]  binary value
//           tens_o  [3:0]  value / 10
//           units_o [3:0]  value mod 10
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bin2bcd60 (
    input  logic [5:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    // Low nibble of (10 * tens). Because the true remainder is below 16,
    // subtracting it modulo 16 from the input's low nibble gives the units.
    logic [3:0] sub;

    always_comb begin
        tens_o = 4'd0;
        sub    = 4'd0;
        if (bin_i >= 6'd60) begin
            tens_o = 4'd6;
            sub    = 4'd12;
        end else if (bin_i >= 6'd50) begin
            tens_o = 4'd5;
            sub    = 4'd2;
        end else if (bin_i >= 6'd40) begin
            tens_o = 4'd4;
            sub    = 4'd8;
        end else if (bin_i >= 6'd30) begin
            tens_o = 4'd3;
            sub    = 4'd14;
        end else if (bin_i >= 6'd20) begin
            tens_o = 4'd2;
            sub    = 4'd4;
        end else if (bin_i >= 6'd10) begin
            tens_o = 4'd1;
            sub    = 4'd10;
        end
        units_o = bin_i[3:0] - sub;
    end

endmodule

`default_nettype wire

// File: rtl/alarm_display.sv
// ============================================================================
// Module  : alarm_display
// Purpose : Four-digit multiplexed 7-segment driver for the alarm clock.
//           Scans digits left to right with a one-clock blank between digits,
//           snapshots the time once per frame, blinks the display while the
//           alarm rings.
// Ports   : Clock, Reset (async, active-low)
//           Hours_C[3:0], Mins_C[5:0], Secs_C[5:0], AM_PM, Alarm, ShowSecs
//           Anode[3:0] (active-low, bit 3 leftmost), Seg[6:0] (gfedcba,
//           active-low), Dp (colon, active-low), PmLed, AlarmLed
// Rev     : 1.0
// ============================================================================
`default_nettype none

module alarm_display
    import alarm_pkg::*;
#(
    parameter int DWELL      = DWELL_DEFAULT,
    parameter int BLINK_HALF = BLINK_HALF_DEFAULT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Hours_C,
    input  logic [5:0] Mins_C,
    input  logic [5:0] Secs_C,
    input  logic       AM_PM,
    input  logic       Alarm,
    input  logic       ShowSecs,
    output logic [3:0] Anode,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic       PmLed,
    output logic       AlarmLed
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_HALF - 1);

    scan_state_e     state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_off_q, blink_off_d;

    logic [3:0] snap_hours_q;
    logic [5:0] snap_mins_q, snap_secs_q;
    logic       snap_pm_q, snap_show_q;

    logic [3:0] anode_q, anode_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic       pm_q, pm_d;
    logic       alm_q, alm_d;

    logic       snap_en;
    logic [5:0] left_val, right_val;
    logic [3:0] left_tens, left_units, right_tens, right_units;
    logic [3:0] digit_val;
    logic       invalid;

    // Snapshot only in the blank slot ahead of the leftmost digit so a frame
    // never mixes two different times.
    assign snap_en = (state_q == ST_BLANK) && (idx_q == 2'd0);

    assign left_val  = snap_show_q ? snap_mins_q : {2'b00, snap_hours_q};
    assign right_val = snap_show_q ? snap_secs_q : snap_mins_q;

    bin2bcd60 u_left (
        .bin_i   (left_val),
        .tens_o  (left_tens),
        .units_o (left_units)
    );

    bin2bcd60 u_right (
        .bin_i   (right_val),
        .tens_o  (right_tens),
        .units_o (right_units)
    );

    assign invalid = (snap_hours_q == 4'd0) || (snap_hours_q > 4'd12) ||
                     (snap_mins_q > 6'd59) ||
                     (snap_show_q && (snap_secs_q > 6'd59));

    // Scan FSM next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        if (state_q == ST_BLANK) begin
            state_d = ST_DRIVE;
            dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            idx_d   = idx_q + 2'd1;
            dwell_d = '0;
        end else begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    // Blink timer: held at phase ON while the alarm is quiet so every new
    // alarm starts visibly.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (!Alarm) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // Output decode from the current state/index; registered below, so the
    // pins trail the scan state by one clock.
    always_comb begin
        case (idx_q)
            2'd0:    digit_val = left_tens;
            2'd1:    digit_val = left_units;
            2'd2:    digit_val = right_tens;
            default: digit_val = right_units;
        endcase

        anode_d = 4'b1111;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        if (state_q == ST_DRIVE) begin
            anode_d = ~(4'b1000 >> idx_q);
            if (invalid) begin
                seg_d = SEG_DASH;
            end else if ((idx_q == 2'd0) && !snap_show_q && (left_tens == 4'd0)) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = seg_digit(digit_val);
            end
            dp_d = !((idx_q == 2'd1) && !snap_secs_q[0]);
        end
        if (Alarm && blink_off_q) begin
            anode_d = 4'b1111;
        end

        pm_d  = snap_pm_q;
        alm_d = Alarm && !blink_off_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_BLANK;
            idx_q        <= 2'd0;
            dwell_q      <= '0;
            blink_cnt_q  <= '0;
            blink_off_q  <= 1'b0;
            snap_hours_q <= 4'd0;
            snap_mins_q  <= 6'd0;
            snap_secs_q  <= 6'd0;
            snap_pm_q    <= 1'b0;
            snap_show_q  <= 1'b0;
            anode_q      <= 4'b1111;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            pm_q         <= 1'b0;
            alm_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dwell_q     <= dwell_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            if (snap_en) begin
                snap_hours_q <= Hours_C;
                snap_mins_q  <= Mins_C;
                snap_secs_q  <= Secs_C;
                snap_pm_q    <= AM_PM;
                snap_show_q  <= ShowSecs;
            end
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            pm_q    <= pm_d;
            alm_q   <= alm_d;
        end
    end

    assign Anode    = anode_q;
    assign Seg      = seg_q;
    assign Dp       = dp_q;
    assign PmLed    = pm_q;
    assign AlarmLed = alm_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_display.sv
// ============================================================================
// Module  : tb_alarm_display
// Purpose : Directed self-checking bench for alarm_display (default DWELL=4,
//           BLINK_HALF=250): reset, HH:MM / MM:SS rendering, blanking,
//           invalid-time dashes, frame snapshot, colon, alarm blink and
//           asynchronous mid-frame reset.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_alarm_display;

    // Active-low gfedcba patterns, hand-derived.
    localparam logic [6:0] P_0 = 7'h40;
    localparam logic [6:0] P_1 = 7'h79;
    localparam logic [6:0] P_2 = 7'h24;
    localparam logic [6:0] P_4 = 7'h19;
    localparam logic [6:0] P_5 = 7'h12;
    localparam logic [6:0] P_8 = 7'h00;
    localparam logic [6:0] P_9 = 7'h10;
    localparam logic [6:0] P_B = 7'h7F;
    localparam logic [6:0] P_D = 7'h3F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
    logic       am_pm;
    logic       alarm;
    logic       show_secs;
    logic [3:0] Anode;
    logic [6:0] Seg;
    logic       Dp;
    logic       PmLed;
    logic       AlarmLed;

    int n_checks = 0;
    int n_fail   = 0;

    alarm_display dut (
        .Clock    (clk),
        .Reset    (rst_n),
        .Hours_C  (hours),
        .Mins_C   (mins),
        .Secs_C   (secs),
        .AM_PM    (am_pm),
        .Alarm    (alarm),
        .ShowSecs (show_secs),
        .Anode    (Anode),
        .Seg      (Seg),
        .Dp       (Dp),
        .PmLed    (PmLed),
        .AlarmLed (AlarmLed)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge on which Anode first shows digit 0 driven.
    task automatic wait_entry();
        logic [3:0] prev;
        bit         found;
        found = 1'b0;
        prev  = Anode;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (Anode == 4'b0111 && prev != 4'b0111) found = 1'b1;
            prev = Anode;
        end
        if (!found) check_val("frame_sync_timeout", 32'd0, 32'd1);
    endtask

    // Called on the first negedge of digit 0; checks the whole 20-clock frame
    // and returns on the first negedge of the next frame.
    task automatic check_frame_here(input string tag,
                                    input logic [6:0] s0, input logic [6:0] s1,
                                    input logic [6:0] s2, input logic [6:0] s3,
                                    input logic dp1, input bit poke);
        logic [6:0] es [4];
        logic [3:0] ea [4];
        logic       edp;
        es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
        ea[0] = 4'b0111; ea[1] = 4'b1011; ea[2] = 4'b1101; ea[3] = 4'b1110;
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 5; k++) begin
                if (poke && d == 2 && k == 0) secs = 6'd59;
                if (k < 4) begin
                    edp = (d == 1) ? dp1 : 1'b1;
                    check_val($sformatf("%s_d%0d_anode", tag, d), {28'd0, Anode}, {28'd0, ea[d]});
                    check_val($sformatf("%s_d%0d_seg", tag, d), {25'd0, Seg}, {25'd0, es[d]});
                    check_val($sformatf("%s_d%0d_dp", tag, d), {31'd0, Dp}, {31'd0, edp});
                end else begin
                    check_val($sformatf("%s_d%0d_gap", tag, d), {28'd0, Anode}, 32'hF);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic set_and_check(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s,
                                 input logic sh, input string tag,
                                 input logic [6:0] s0, input logic [6:0] s1,
                                 input logic [6:0] s2, input logic [6:0] s3,
                                 input logic dp1);
        hours = h; mins = m; secs = s; show_secs = sh;
        wait_entry();
        wait_entry();
        check_frame_here(tag, s0, s1, s2, s3, dp1, 1'b0);
    endtask

    initial begin
        int         bad;
        int         seen;
        logic [3:0] a1;
        logic [3:0] a2;

        rst_n = 1'b0; hours = 4'd9; mins = 6'd5; secs = 6'd0;
        am_pm = 1'b0; alarm = 1'b0; show_secs = 1'b0;

        // Reset held for three clocks.
        repeat (3) @(negedge clk);
        check_val("rst_anode", {28'd0, Anode}, 32'hF);
        check_val("rst_seg", {25'd0, Seg}, 32'h7F);
        check_val("rst_dp", {31'd0, Dp}, 32'd1);
        check_val("rst_pmled", {31'd0, PmLed}, 32'd0);
        check_val("rst_alarmled", {31'd0, AlarmLed}, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check_val("rel_clk1_anode", {28'd0, Anode}, 32'hF);
        @(negedge clk);
        // Digit 0 driven on the second clock: "_905", colon on (secs even).
        check_frame_here("hh0905", P_B, P_9, P_0, P_5, 1'b0, 1'b0);

        // MM:SS mode, then a mid-frame seconds change must not tear.
        set_and_check(4'd9, 6'd59, 6'd58, 1'b1, "mmss5958", P_5, P_9, P_5, P_8, 1'b0);
        check_frame_here("tear", P_5, P_9, P_5, P_8, 1'b0, 1'b1);
        check_frame_here("sec59", P_5, P_9, P_5, P_9, 1'b1, 1'b0);

        // Invalid values render dashes.
        set_and_check(4'd9, 6'd60, 6'd59, 1'b0, "min60", P_D, P_D, P_D, P_D, 1'b1);
        set_and_check(4'd0, 6'd30, 6'd58, 1'b0, "hour0", P_D, P_D, P_D, P_D, 1'b0);
        set_and_check(4'd13, 6'd7, 6'd7, 1'b0, "hour13", P_D, P_D, P_D, P_D, 1'b1);

        // Hour 12 upper boundary, no leading blank; PM indicator.
        am_pm = 1'b1;
        set_and_check(4'd12, 6'd0, 6'd58, 1'b0, "hh1200", P_1, P_2, P_0, P_0, 1'b0);
        check_val("pmled", {31'd0, PmLed}, 32'd1);

        // Out-of-range seconds are ignored while not shown.
        set_and_check(4'd10, 6'd45, 6'd61, 1'b0, "hh1045", P_1, P_0, P_4, P_5, 1'b1);
        set_and_check(4'd10, 6'd45, 6'd60, 1'b1, "sec60", P_D, P_D, P_D, P_D, 1'b0);

        // Alarm blink.
        hours = 4'd9; mins = 6'd5; secs = 6'd0; show_secs = 1'b0;
        wait_entry();
        alarm = 1'b1;
        bad = 0; seen = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (AlarmLed !== 1'b1) bad++;
            if (Anode != 4'b1111) seen = 1;
        end
        check_val("alarm_on_phase", bad, 0);
        check_val("alarm_on_scans", seen, 1);
        bad = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (AlarmLed !== 1'b0 || Anode !== 4'b1111) bad++;
        end
        check_val("alarm_off_phase", bad, 0);
        @(negedge clk);
        check_val("alarm_on_again", {31'd0, AlarmLed}, 32'd1);
        repeat (259) @(negedge clk);
        check_val("alarm_mid_off_anode", {28'd0, Anode}, 32'hF);
        check_val("alarm_mid_off_led", {31'd0, AlarmLed}, 32'd0);
        alarm = 1'b0;
        @(negedge clk);
        a1 = Anode;
        check_val("alarm_drop_led", {31'd0, AlarmLed}, 32'd0);
        @(negedge clk);
        a2 = Anode;
        check_val("alarm_drop_resume", {31'd0, (a1 != 4'b1111) || (a2 != 4'b1111)}, 32'd1);
        alarm = 1'b1;
        @(negedge clk);
        check_val("alarm_rise_on", {31'd0, AlarmLed}, 32'd1);
        alarm = 1'b0;

        // Asynchronous reset during digit 2.
        wait_entry();
        alarm = 1'b1;
        repeat (10) @(negedge clk);
        check_val("pre_rst_digit2", {28'd0, Anode}, 32'hD);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_anode", {28'd0, Anode}, 32'hF);
        check_val("arst_seg", {25'd0, Seg}, 32'h7F);
        check_val("arst_dp", {31'd0, Dp}, 32'd1);
        check_val("arst_pmled", {31'd0, PmLed}, 32'd0);
        check_val("arst_alarmled", {31'd0, AlarmLed}, 32'd0);
        alarm = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("arst_rel_clk1", {28'd0, Anode}, 32'hF);
        @(negedge clk);
        check_val("arst_rel_digit0", {28'd0, Anode}, 32'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
